// File: rtl/wr_burst_pkg.sv
// Shared types and constants for the VDMA write-burst buffer.
package wr_burst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_e;

    // Width of burst_len (AXI awlen encoding).
    localparam int BURST_LEN_W = 8;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy count and sticky dropped-write flag.
module sync_fifo_fwft
    import wr_burst_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_i,
    input  logic [WIDTH-1:0]              wr_data_i,
    input  logic                          rd_en_i,
    output logic [WIDTH-1:0]              rd_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [count_width(DEPTH)-1:0] count_o,
    output logic                          drop_o
);

    localparam int CW = count_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             drop_q;
    logic             wr_ok, rd_ok;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign wr_ok     = wr_en_i && !full_o;
    assign rd_ok     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rptr_q];
    assign count_o   = count_q;
    assign drop_o    = drop_q;

    // Pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + 1'b1;
            if (rd_ok) rptr_q <= rptr_q + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (wr_en_i && full_o) drop_q <= 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/wr_burst_fifo.sv
// VDMA write-path burst buffer: buffers packed words and emits AXI-style
// request + data bursts, flushing short bursts on end-of-frame.
// Optional feature macro WR_BURST_STRB_EN: store imask per entry and drive
// it on wstrb; otherwise wstrb is all ones while wvalid.
module wr_burst_fifo
    import wr_burst_pkg::*;
#(
    parameter int DSIZE     = 256,
    parameter int DEPTH     = 64,
    parameter int BURST_LEN = 16
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   iwr_en,
    input  logic [DSIZE-1:0]       idata,
    input  logic [DSIZE/8-1:0]     imask,
    input  logic                   ilast_en,
    output logic                   burst_req,
    output logic [BURST_LEN_W-1:0] burst_len,
    input  logic                   burst_ack,
    output logic [DSIZE-1:0]       wdata,
    output logic [DSIZE/8-1:0]     wstrb,
    output logic                   wvalid,
    input  logic                   wready,
    output logic                   wlast,
    output logic                   full,
    output logic                   overflow
);

    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0]          BURST_LEN_C = CW'(BURST_LEN);
    localparam logic [BURST_LEN_W-1:0] LEN_FULL    = BURST_LEN_W'(BURST_LEN - 1);

`ifdef WR_BURST_STRB_EN
    localparam int EW = DSIZE + DSIZE / 8;
`else
    localparam int EW = DSIZE;
`endif

    state_e                 state_q, state_d;
    logic [BURST_LEN_W-1:0] len_q, len_d;
    logic [BURST_LEN_W-1:0] beat_q, beat_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   flush_burst_q, flush_burst_d;

    logic [EW-1:0]          fifo_din, fifo_dout;
    logic [CW-1:0]          count;
    logic                   fifo_empty;

`ifdef WR_BURST_STRB_EN
    assign fifo_din = {imask, idata};
    assign wstrb    = wvalid ? fifo_dout[EW-1:DSIZE] : '0;
`else
    logic unused_mask;
    assign unused_mask = ^imask;
    assign fifo_din    = idata;
    assign wstrb       = wvalid ? '1 : '0;
`endif

    sync_fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst       (rst),
        .wr_en_i   (iwr_en),
        .wr_data_i (fifo_din),
        .rd_en_i   (wvalid && wready),
        .rd_data_o (fifo_dout),
        .full_o    (full),
        .empty_o   (fifo_empty),
        .count_o   (count),
        .drop_o    (overflow)
    );

    assign burst_req = (state_q == REQ);
    assign burst_len = len_q;
    assign wvalid    = (state_q == DATA);
    assign wlast     = wvalid && (beat_q == '0);
    // Gated so wdata reads zero outside DATA, including straight after reset.
    assign wdata     = wvalid ? fifo_dout[DSIZE-1:0] : '0;

    // State, burst length, beat counter and flush bookkeeping registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            len_q         <= '0;
            beat_q        <= '0;
            flush_pend_q  <= 1'b0;
            flush_burst_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            flush_pend_q  <= flush_pend_d;
            flush_burst_q <= flush_burst_d;
        end
    end

    // Burst decision: full-length threshold first, then short flush bursts.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        beat_d        = beat_q;
        flush_burst_d = flush_burst_q;
        flush_pend_d  = flush_pend_q | ilast_en;
        case (state_q)
            IDLE: begin
                if (count >= BURST_LEN_C) begin
                    state_d       = REQ;
                    len_d         = LEN_FULL;
                    flush_burst_d = 1'b0;
                end else if (flush_pend_q && !fifo_empty) begin
                    state_d       = REQ;
                    len_d         = BURST_LEN_W'(count - CW'(1));
                    flush_burst_d = 1'b1;
                end else if (flush_pend_q) begin
                    flush_pend_d = ilast_en;
                end
            end
            REQ: begin
                if (burst_ack) begin
                    state_d = DATA;
                    beat_d  = len_q;
                end
            end
            DATA: begin
                if (wready) begin
                    if (beat_q == '0) begin
                        state_d = IDLE;
                        if (flush_burst_q) flush_pend_d = ilast_en;
                    end else begin
                        beat_d = beat_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wr_burst_fifo.sv
// Directed self-checking bench for wr_burst_fifo.
module tb_wr_burst_fifo;

    localparam int DSIZE = 256;
    localparam int DEPTH = 64;
    localparam int BL    = 16;

    logic             clock;
    logic             rst;
    logic             iwr_en;
    logic [DSIZE-1:0] idata;
    logic [31:0]      imask;
    logic             ilast_en;
    logic             burst_req;
    logic [7:0]       burst_len;
    logic             burst_ack;
    logic [DSIZE-1:0] wdata;
    logic [31:0]      wstrb;
    logic             wvalid;
    logic             wready;
    logic             wlast;
    logic             full;
    logic             overflow;

    wr_burst_fifo #(
        .DSIZE     (DSIZE),
        .DEPTH     (DEPTH),
        .BURST_LEN (BL)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .iwr_en    (iwr_en),
        .idata     (idata),
        .imask     (imask),
        .ilast_en  (ilast_en),
        .burst_req (burst_req),
        .burst_len (burst_len),
        .burst_ack (burst_ack),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .wlast     (wlast),
        .full      (full),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int nwr;
        bit last;
        int nb;
        int len0;
        int len1;
    } vec_t;

    vec_t vecs [3];

    int total = 0;
    int bad   = 0;
    int seq   = 0;
    logic [DSIZE-1:0] qd [$];
    logic [31:0]      qm [$];

    function automatic logic [DSIZE-1:0] mkdata(input int s);
        logic [31:0] w;
        w = 32'(s) ^ 32'hA5A5_0000;
        return {8{w}};
    endfunction

    function automatic logic [31:0] mkmask(input int s);
        return 32'(s * 7 + 1) ^ 32'h0F0F_F0F0;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            iwr_en = 1'b1;
            idata  = mkdata(seq);
            imask  = mkmask(seq);
            if (!full) begin
                qd.push_back(mkdata(seq));
                qm.push_back(mkmask(seq));
            end
            seq++;
            tick();
        end
        iwr_en = 1'b0;
    endtask

    task automatic pulse_last();
        ilast_en = 1'b1;
        tick();
        ilast_en = 1'b0;
    endtask

    // Wait for a request, acknowledge it, then collect beats against the scoreboard.
    task automatic service_burst(input int len, input bit rnd);
        int t;
        int hs;
        bit stalled;
        logic [DSIZE-1:0] prev;
        logic [DSIZE-1:0] ed;
        logic [31:0] em;
        t = 0;
        while (!burst_req && t < 300) begin
            tick();
            t++;
        end
        if (!burst_req) begin
            chk("req_timeout", 0, 1);
            return;
        end
        chk("burst_len", burst_len, len - 1);
        burst_ack = 1'b1;
        tick();
        burst_ack = 1'b0;
        hs = 0;
        t = 0;
        stalled = 1'b0;
        prev = '0;
        while (hs < len && t < 1000) begin
            wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("wvalid_hi", wvalid, 1);
            if (stalled) chk("wdata_stable", wdata, prev);
            if (wready) begin
                if (qd.size() > 0) begin
                    ed = qd.pop_front();
                    em = qm.pop_front();
                end else begin
                    ed = '0;
                    em = '0;
                end
                chk("wdata", wdata, ed);
`ifdef WR_BURST_STRB_EN
                chk("wstrb", wstrb, em);
`else
                chk("wstrb", wstrb, 32'hFFFF_FFFF);
`endif
                chk("wlast", wlast, (hs == len - 1));
                hs++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev = wdata;
            end
            tick();
            t++;
        end
        wready = 1'b0;
        chk("beats", hs, len);
        chk("wvalid_after", wvalid, 0);
        chk("idle_gap_req", burst_req, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{nwr: 16, last: 1'b0, nb: 1, len0: 16, len1: 0};
        vecs[1] = '{nwr: 5,  last: 1'b1, nb: 1, len0: 5,  len1: 0};
        vecs[2] = '{nwr: 20, last: 1'b1, nb: 2, len0: 16, len1: 4};

        rst = 1'b1;
        iwr_en = 1'b0;
        idata = '0;
        imask = '0;
        ilast_en = 1'b0;
        burst_ack = 1'b0;
        wready = 1'b0;
        tick();
        tick();
        chk("rst_burst_req", burst_req, 0);
        chk("rst_burst_len", burst_len, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wlast", wlast, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wstrb", wstrb, 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 3; v++) begin
            write_words(vecs[v].nwr);
            if (vecs[v].last) pulse_last();
            service_burst(vecs[v].len0, 1'b0);
            if (vecs[v].nb > 1) service_burst(vecs[v].len1, 1'b0);
            repeat (3) tick();
            chk("vec_count", dut.count, 0);
            chk("vec_flush_pend", dut.flush_pend_q, 0);
            chk("vec_no_req", burst_req, 0);
        end

        // Random wready stalls during a full-length burst.
        write_words(16);
        service_burst(16, 1'b1);
        chk("stall_count", dut.count, 0);

        // Overflow: DEPTH+3 writes with no acknowledge.
        write_words(DEPTH + 3);
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", dut.count, DEPTH);
        chk("ovf_accepted", qd.size(), DEPTH);
        for (int b = 0; b < DEPTH / BL; b++) service_burst(16, 1'b0);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_full_clear", full, 0);
        chk("ovf_drained", dut.count, 0);

        // Reset during beat 7 of a burst.
        write_words(16);
        begin
            int t;
            t = 0;
            while (!burst_req && t < 300) begin
                tick();
                t++;
            end
            chk("rb_req", burst_req, 1);
            burst_ack = 1'b1;
            tick();
            burst_ack = 1'b0;
            wready = 1'b1;
            repeat (6) tick();
            chk("rb_mid_wvalid", wvalid, 1);
            rst = 1'b1;
            #1;
            chk("rb_wvalid", wvalid, 0);
            chk("rb_wlast", wlast, 0);
            chk("rb_burst_req", burst_req, 0);
            chk("rb_burst_len", burst_len, 0);
            chk("rb_wdata", wdata, 0);
            chk("rb_wstrb", wstrb, 0);
            chk("rb_overflow", overflow, 0);
            chk("rb_full", full, 0);
            chk("rb_count", dut.count, 0);
            #2;
            rst = 1'b0;
            wready = 1'b0;
            qd.delete();
            qm.delete();
            tick();
        end
        write_words(16);
        service_burst(16, 1'b0);
        repeat (2) tick();
        chk("post_rst_count", dut.count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wr_burst_fifo.md
# wr_burst_fifo

Write-path stage directly downstream of the pixel-packing stage in the VDMA write channel. Buffers packed DSIZE-bit words, their byte masks and end-of-frame markers. Emits AXI-style write bursts: a burst request carrying the length, then the data beats with `wlast`. Frame ends are flushed as a short burst, so no partial data is stranded in the buffer.

## Interface
- `DSIZE`, 256: data word width; multiple of 8.
- `DEPTH`, 64: buffer entries; power of two, ≥ 2×`BURST_LEN`.
- `BURST_LEN`, 16: nominal beats per burst; 1..256.

- `clock`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `iwr_en`  in  1: write strobe for `idata`/`imask`.
- `idata`  in  DSIZE: packed word.
- `imask`  in  DSIZE/8: byte-valid mask for `idata`.
- `ilast_en`  in  1: end-of-frame pulse; requests a flush.
- `burst_req`  out  1: burst request, held until acknowledged.
- `burst_len`  out  8: beats−1 (AXI `awlen` encoding); stable while `burst_req`.
- `burst_ack`  in  1: request accepted.
- `wdata`  out  DSIZE: beat data.
- `wstrb`  out  DSIZE/8: beat byte strobes.
- `wvalid`  out  1: beat valid.
- `wready`  in  1: beat accepted.
- `wlast`  out  1: final beat of the burst.
- `full`  out  1: buffer holds DEPTH entries.
- `overflow`  out  1: sticky; a write was dropped.

## Operation
- Buffer: first-word-fall-through FIFO with occupancy `count` (0..DEPTH).
  - Writes occur when `iwr_en && !full`.
  - A read occurs on each beat handshake (`wvalid && wready`).
  - Simultaneous read and write leave `count` unchanged.
  - Write while full: word dropped, `overflow` set to 1 until reset.
- Flush: `ilast_en` sets `flush_pend`. A word written in the same cycle is included in the flush.
- State machine states: IDLE, REQ, DATA.
  - IDLE, `count ≥ BURST_LEN`: go to REQ with length BURST_LEN. Threshold takes priority over flush.
  - IDLE, `flush_pend && count>0 && count<BURST_LEN`: go to REQ with length `count`; mark the burst as a flush burst.
  - IDLE, `flush_pend && count==0`: clear `flush_pend`, stay in IDLE.
  - REQ: `burst_req`=1 and `burst_len`=length−1, both held constant. On `burst_ack`, go to DATA and load the beat counter with length−1.
  - DATA: `wvalid`=1; the data is guaranteed present because length ≤ `count` at the REQ decision. Each handshake decrements the beat counter. `wlast`=1 when the counter is 0. The handshake on `wlast` returns to IDLE.
- Flush-burst completion: `flush_pend` clears unless a new `ilast_en` arrives in the same cycle, in which case it stays set.
- `ilast_en` while a burst is in REQ or DATA: `flush_pend` is set and evaluated on return to IDLE.
- `wvalid` never drops mid-burst while waiting on `wready`. `wdata`/`wstrb`/`wlast` are held stable until the handshake.

## Timing
- Reset values: `burst_req`, `burst_len`, `wvalid`, `wlast`, `full`, `overflow` = 0; `wdata`, `wstrb` = 0. State IDLE, `count` 0, `flush_pend` 0.
- A write at cycle N is reflected in `count`/`full` at N+1. IDLE evaluates registered `count`, so `burst_req` rises at N+2 at the earliest.
- `burst_ack` in the same cycle `burst_req` rises is legal: one REQ cycle, then DATA next cycle.
- DATA with `wready` held high: one beat per cycle. A BURST_LEN burst occupies BURST_LEN cycles after REQ.
- After the `wlast` handshake, IDLE lasts one cycle minimum before the next `burst_req`.
- Reset asserted mid-burst: all state cleared immediately. Buffered data is discarded and `wvalid` drops asynchronously.

## Configuration
- `WR_BURST_STRB_EN`
  - Defined: `imask` is stored per entry and presented on `wstrb`.
  - Undefined: `imask` is ignored, the mask storage is not built, and `wstrb` is all ones whenever `wvalid`=1 (0 otherwise, and at reset).

## Structure
- Package `wr_burst_pkg`:
  - state enumeration (IDLE/REQ/DATA);
  - `BURST_LEN_W`=8 constant;
  - clog2-based width helper for `count` (width clog2(DEPTH)+1).
- Sub-module `sync_fifo_fwft`: parameterised width/depth, `full`/`empty`/`count`, dropped-write flag. Top level holds the FSM, flush logic and beat counter.

## Test plan
- 16 consecutive writes, `burst_ack` on first request, `wready`=1 → `burst_req` with `burst_len`=15; 16 beats in order; `wlast` on beat 16; `count` returns to 0.
- 5 writes then `ilast_en` → one request with `burst_len`=4; 5 beats, `wlast` on the 5th; `flush_pend` cleared.
- 20 writes then `ilast_en`, `wready`=1 → bursts of 16 then 4 beats (`burst_len` 15 then 3), data order preserved.
- `wready` toggled randomly during a 16-beat burst → `wvalid` stays high; `wdata` stable across stalls; exactly 16 handshakes.
- DEPTH+3 writes with `burst_ack` held low → `full`=1 after 64 writes; 3 words dropped; `overflow`=1 and remains set after draining.
- `rst` pulsed during beat 7 of a burst → all outputs return to reset values at once; the next 16 writes produce a clean burst.
